// File: rtl/reg_bus_scan_pkg.sv
// Shared types for the register-bus scan reader.
// State encoding and index-width helper.
package reg_bus_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_HOLD   = 2'd2,
        ST_TURN   = 2'd3
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_bus_onehot_sel.sv
// Active-low one-hot chip-select decoder.
// All selects stay high (bus floating) while en is low.
module reg_bus_onehot_sel
    import reg_bus_scan_pkg::*;
#(
    parameter int NrOfRegs = 4,
    parameter int IdxW     = idx_width(NrOfRegs)
) (
    input  logic [IdxW-1:0]     idx,
    input  logic                en,
    output logic [NrOfRegs-1:0] cs
);

    always_comb begin
        cs = '1;
        if (en) begin
            cs[idx] = 1'b0;
        end
    end

endmodule

// File: rtl/reg_bus_scan_reader.sv
// Scans a tri-state register bus one select at a time, streams words out.
// Define REG_BUS_SCAN_PRESET_CHECK_EN to add out_preset / any_preset flags.
module reg_bus_scan_reader
    import reg_bus_scan_pkg::*;
#(
    parameter int NrOfBits     = 8,
    parameter int NrOfRegs     = 4,
    parameter int SettleCycles = 2
) (
    input  logic                             Clock,
    input  logic                             Reset_n,
    input  logic                             Tick,
    input  logic                             start,
    input  logic [NrOfBits-1:0]              Bus,
    output logic [NrOfRegs-1:0]              cs,
    output logic [NrOfBits-1:0]              out_data,
    output logic [idx_width(NrOfRegs)-1:0]   out_index,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy,
    output logic                             done
`ifdef REG_BUS_SCAN_PRESET_CHECK_EN
    ,
    output logic                             out_preset,
    output logic                             any_preset
`endif
);

    localparam int IdxW = idx_width(NrOfRegs);
    localparam int CntW = idx_width(SettleCycles);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NrOfRegs - 1);
    localparam logic [CntW-1:0] SettleLoad = CntW'(SettleCycles - 1);

    state_t          state;
    logic [IdxW-1:0] idx;
    logic [CntW-1:0] cnt;
    logic            accept;
    logic            last;

    assign accept = out_valid & out_ready;
    assign last   = (idx == LastIdx);

    // cs decodes from registered state, so async reset floats the bus at once
    reg_bus_onehot_sel #(
        .NrOfRegs (NrOfRegs),
        .IdxW     (IdxW)
    ) u_sel (
        .idx (idx),
        .en  (state == ST_SELECT),
        .cs  (cs)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_index <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef REG_BUS_SCAN_PRESET_CHECK_EN
            out_preset <= 1'b0;
            any_preset <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start && Tick) begin
                        state <= ST_SELECT;
                        idx   <= '0;
                        cnt   <= SettleLoad;
                        busy  <= 1'b1;
`ifdef REG_BUS_SCAN_PRESET_CHECK_EN
                        any_preset <= 1'b0;
`endif
                    end
                end
                ST_SELECT: begin
                    if (Tick) begin
                        if (cnt == '0) begin
                            out_data  <= Bus;
                            out_index <= idx;
                            out_valid <= 1'b1;
                            state     <= ST_HOLD;
`ifdef REG_BUS_SCAN_PRESET_CHECK_EN
                            out_preset <= &Bus;
                            if (&Bus) begin
                                any_preset <= 1'b1;
                            end
`endif
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                // handshake completes regardless of Tick
                ST_HOLD: begin
                    if (accept) begin
                        out_valid <= 1'b0;
                        if (last) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_TURN;
                        end
                    end
                end
                ST_TURN: begin
                    if (Tick) begin
                        idx   <= idx + 1'b1;
                        cnt   <= SettleLoad;
                        state <= ST_SELECT;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_scan_reader.sv
// Self-checking bench for reg_bus_scan_reader with a register-bank model.
// Preset flags are checked when REG_BUS_SCAN_PRESET_CHECK_EN is defined.
module tb_reg_bus_scan_reader;
    import reg_bus_scan_pkg::*;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int S  = 2;
    localparam int IW = idx_width(N);

    logic          Clock = 1'b0;
    logic          Reset_n = 1'b0;
    logic          Tick = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b1;
    logic [W-1:0]  Bus;
    logic [N-1:0]  cs;
    logic [W-1:0]  out_data;
    logic [IW-1:0] out_index;
    logic          out_valid;
    logic          busy;
    logic          done;
`ifdef REG_BUS_SCAN_PRESET_CHECK_EN
    logic          out_preset;
    logic          any_preset;
    bit            got_pre[$];
`endif

    logic [W-1:0] regs [N];
    int tests = 0;
    int fails = 0;
    int tmode = 0;
    int tick_edges = 0;
    int done_cnt = 0;
    int overlap_err = 0;
    int gap_err = 0;
    int outside_err = 0;
    int run_len = 0;
    int runs[$];
    int got_idx[$];
    int got_data[$];
    logic [N-1:0] prev_cs = '1;

    reg_bus_scan_reader #(
        .NrOfBits     (W),
        .NrOfRegs     (N),
        .SettleCycles (S)
    ) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .Tick      (Tick),
        .start     (start),
        .Bus       (Bus),
        .cs        (cs),
        .out_data  (out_data),
        .out_index (out_index),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
`ifdef REG_BUS_SCAN_PRESET_CHECK_EN
        ,
        .out_preset (out_preset),
        .any_preset (any_preset)
`endif
    );

    always #5 Clock = ~Clock;

    // register bank: selected register drives, otherwise the bus floats
    always_comb begin
        Bus = 8'hA5;
        for (int i = 0; i < N; i++) begin
            if (!cs[i]) Bus = regs[i];
        end
    end

    always @(posedge Clock) begin
        if (Tick) tick_edges++;
        if (Reset_n && done) done_cnt++;
        if (Reset_n && out_valid && out_ready) begin
            got_idx.push_back(int'(out_index));
            got_data.push_back(int'(out_data));
`ifdef REG_BUS_SCAN_PRESET_CHECK_EN
            got_pre.push_back(out_preset);
`endif
        end
    end

    always @(negedge Clock) begin
        int zeros;
        zeros = N - $countones(cs);
        if (zeros > 1) overlap_err++;
        if (zeros > 0 && !busy) outside_err++;
        if (zeros == 1 && prev_cs != '1 && prev_cs != cs) gap_err++;
        if (zeros > 0) begin
            run_len++;
        end else if (run_len > 0) begin
            runs.push_back(run_len);
            run_len = 0;
        end
        prev_cs = cs;
    end

    initial begin : tick_drv
        int ph;
        ph = 0;
        forever begin
            @(posedge Clock);
            #1;
            ph = (ph + 1) % 3;
            case (tmode)
                0:       Tick = 1'b1;
                1:       Tick = (ph == 0);
                default: Tick = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(output int lat);
        int k;
        int t0;
        k = 0;
        @(negedge Clock);
        start = 1'b1;
        while (!busy && k < 40) begin
            @(negedge Clock);
            k++;
        end
        start = 1'b0;
        check("start_accept", 32'(busy), 1);
        t0 = tick_edges;
`ifdef REG_BUS_SCAN_PRESET_CHECK_EN
        check("any_preset_clear", 32'(any_preset), 0);
`endif
        k = 0;
        while (!out_valid && k < 100) begin
            @(negedge Clock);
            k++;
        end
        check("first_valid_seen", 32'(out_valid), 1);
        lat = tick_edges - t0 + 1;
    endtask

    task automatic run_scan(input bit rnd_regs, input int mode,
                            input bit rnd_ready, input int stall_idx,
                            input bit mid_start);
        int d0;
        int cyc;
        int lat;
        bit stalled;
        bit exp_any;
        d0 = done_cnt;
        cyc = 0;
        stalled = 0;
        tmode = mode;
        if (rnd_regs) begin
            for (int i = 0; i < N; i++) regs[i] = W'($urandom);
        end
        got_idx.delete();
        got_data.delete();
`ifdef REG_BUS_SCAN_PRESET_CHECK_EN
        got_pre.delete();
`endif
        runs.delete();
        out_ready = 1'b1;
        do_start(lat);
        check("latency_ticks", 32'(lat), S + 1);
        while (done_cnt == d0 && cyc < 800) begin
            @(negedge Clock);
            cyc++;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            if (mid_start) start = (cyc >= 3 && cyc <= 6);
            if (stall_idx >= 0 && !stalled && out_valid &&
                int'(out_index) == stall_idx) begin
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge Clock);
                    check("stall_data", 32'(out_data), 32'(regs[stall_idx]));
                    check("stall_index", 32'(out_index), 32'(stall_idx));
                    check("stall_valid", 32'(out_valid), 1);
                    check("stall_cs", 32'(cs), 32'({N{1'b1}}));
                end
                stalled = 1;
                out_ready = 1'b1;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("scan_timeout", 32'(cyc < 800), 1);
        @(negedge Clock);
        check("busy_after_done", 32'(busy), 0);
        check("valid_after_done", 32'(out_valid), 0);
        check("word_count", 32'(got_idx.size()), N);
        for (int i = 0; i < N && i < got_idx.size(); i++) begin
            check("word_index", 32'(got_idx[i]), 32'(i));
            check("word_data", 32'(got_data[i]), 32'(regs[i]));
        end
        if (mode != 2) begin
            check("run_count", 32'(runs.size()), N);
            foreach (runs[i]) check("cs_low_len", 32'(runs[i]),
                                    32'(mode == 1 ? 3 * S : S));
        end
        exp_any = 0;
        for (int i = 0; i < N; i++) if (regs[i] == '1) exp_any = 1;
`ifdef REG_BUS_SCAN_PRESET_CHECK_EN
        for (int i = 0; i < N && i < got_pre.size(); i++)
            check("out_preset", 32'(got_pre[i]), 32'(regs[i] == '1));
        check("any_preset", 32'(any_preset), 32'(exp_any));
`endif
        repeat (8) @(negedge Clock);
        check("single_done", 32'(done_cnt - d0), 1);
        check("no_restart", 32'(busy), 0);
    endtask

    initial begin : main
        int k;
        int d;
        regs[0] = 8'h11;
        regs[1] = 8'h22;
        regs[2] = 8'h33;
        regs[3] = 8'h44;
        #12;
        @(negedge Clock);
        check("rst_cs", 32'(cs), 32'({N{1'b1}}));
        check("rst_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_index", 32'(out_index), 0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clock);

        run_scan(0, 0, 0, -1, 0);
        run_scan(0, 0, 0, 1, 0);
        run_scan(0, 1, 0, -1, 0);
        for (int r = 0; r < 3; r++) run_scan(1, 2, 1, -1, 0);
        run_scan(1, 0, 0, -1, 1);

        // abort a scan with reset while register 2 drives the bus
        tmode = 0;
        regs[0] = 8'h11;
        regs[1] = 8'h22;
        regs[2] = 8'h33;
        regs[3] = 8'h44;
        @(negedge Clock);
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        k = 0;
        while (cs[2] !== 1'b0 && k < 200) begin
            @(negedge Clock);
            k++;
        end
        check("reach_cs2", 32'(cs[2]), 0);
        d = done_cnt;
        #1 Reset_n = 1'b0;
        #1;
        check("async_rst_cs", 32'(cs), 32'({N{1'b1}}));
        check("async_rst_valid", 32'(out_valid), 0);
        check("async_rst_busy", 32'(busy), 0);
        repeat (4) @(negedge Clock);
        check("abort_no_done", 32'(done_cnt - d), 0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clock);

        run_scan(0, 0, 0, -1, 0);
`ifdef REG_BUS_SCAN_PRESET_CHECK_EN
        for (int i = 0; i < N - 1; i++) regs[i] = W'($urandom_range(0, 254));
        regs[N-1] = '1;
        run_scan(0, 0, 1, -1, 0);
        regs[N-1] = 8'h5A;
        run_scan(0, 0, 0, -1, 0);
`endif

        check("cs_overlap", 32'(overlap_err), 0);
        check("cs_gap", 32'(gap_err), 0);
        check("cs_outside", 32'(outside_err), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_bus_scan_reader.md
Name: reg_bus_scan_reader

Overview:
Read-side master for the shared tri-state register bus. It scans a bank of NrOfRegs bus registers in order. Each register drives the bus only while its cs input is low and floats the bus when cs is high. The reader drives one cs line low at a time, waits a settle time, and captures the bus value. Each captured word is delivered downstream on a valid/ready stream tagged with its register index. Sits between the register bank and the result/display logic.

Parameters:
NrOfBits, 8, bus and data width
NrOfRegs, 4, registers on the bus (>=2)
SettleCycles, 2, Tick-qualified cycles cs is held low before capture (>=1)

Ports:
Clock  in  1  system clock, all state on rising edge
Reset_n  in  1  asynchronous, active-low reset
Tick  in  1  clock-enable strobe; FSM advances only on Clock edges with Tick=1
start  in  1  begin one full scan; sampled in IDLE with Tick=1
Bus  in  NrOfBits  shared tri-state register bus
cs  out  NrOfRegs  per-register select; 1 = register floats the bus, 0 = register drives it
out_data  out  NrOfBits  captured word
out_index  out  IDXW  register index of out_data; IDXW = max(1, clog2(NrOfRegs))
out_valid  out  1  out_data/out_index valid
out_ready  in  1  downstream accept
busy  out  1  scan in progress
done  out  1  one-Clock pulse after the last word is accepted

Behaviour:
- Reset (Reset_n=0, asynchronous): cs = all ones, out_valid=0, busy=0, done=0, out_data=0, out_index=0, state=IDLE, settle counter=0. cs returns to all ones immediately, not at a clock edge. Mid-scan reset aborts the scan with no done pulse.
- State IDLE: cs all ones. start&Tick -> SELECT, idx=0, busy=1.
- State SELECT: cs[idx]=0, all other cs bits =1. The settle counter loads SettleCycles-1 on entry. Each Tick decrements it. On a Tick with counter==0:
  - out_data<=Bus, out_index<=idx, out_valid<=1
  - cs<=all ones
  - go to HOLD
- Latency: from start accepted to out_valid = SettleCycles+1 Ticks. With Tick tied high and SettleCycles=2, this is 3 Clocks.
- State HOLD: out_valid=1; out_data and out_index stay stable until accepted. Acceptance is out_valid&out_ready and is not gated by Tick.
  - On accept with idx==NrOfRegs-1: out_valid<=0, busy<=0, done<=1 for one Clock, go to IDLE.
  - Otherwise: out_valid<=0, go to TURN.
- State TURN: cs all ones for one Tick (bus turnaround, so no two registers ever drive the bus together). Then idx<=idx+1 and go to SELECT.
- Invariant: at most one cs bit is low in any cycle, and cs is never low outside SELECT.
- start while busy is ignored and not queued. start without Tick is ignored.
- Tick low freezes SELECT, TURN and the settle counter. HOLD still completes its handshake.
- out_ready while out_valid=0 has no effect.
- Index arithmetic is unsigned IDXW bits. idx never exceeds NrOfRegs-1, so there is no wrap.

Optional Feature:
Macro REG_BUS_SCAN_PRESET_CHECK_EN.
- Enabled:
  - Adds output out_preset (1 bit), valid with out_valid; it is 1 when the captured word is all ones, i.e. a preset register.
  - Adds sticky output any_preset, cleared when a scan starts and set if any word in the scan had out_preset=1.
  - Both reset to 0.
- Disabled: neither port exists and there is no extra logic.

Decomposition:
- Shared package holds the state encoding (IDLE, SELECT, HOLD, TURN as a 2-bit enum) and the IDXW width function.
- One natural sub-module: reg_bus_onehot_sel. It is combinational, decoding idx plus an enable into active-low one-hot cs, all ones when disabled.

Test Plan:
- NrOfRegs=4, SettleCycles=2, Tick=1, out_ready=1. Registers hold 8'h11, 8'h22, 8'h33, 8'h44; pulse start. Required: words 11,22,33,44 with indices 0..3; each cs bit low for exactly 2 Clocks; done pulses once; busy drops with done.
- Same setup with out_ready low for 5 Clocks on word 1. Required: out_data=8'h22 and out_index=1 held stable; cs all ones during the stall; scan resumes after accept.
- Tick asserted every 3rd Clock. Required: cs[0] stays low for 6 Clocks; out_valid first rises 9 Clocks after the accepted start; results identical to the first scenario.
- Pulse start again mid-scan. Required: ignored, exactly 4 words and one done. Then assert Reset_n=0 while cs[2]=0. Required: cs=4'b1111 before the next Clock edge; out_valid=0; no done.
- Monitor cs in every cycle across all scenarios. Required: never two zero bits, and at least one all-ones cycle between successive selects.
- With REG_BUS_SCAN_PRESET_CHECK_EN defined and register 3 preset to 8'hFF. Required: out_preset=1 only with index 3; any_preset=1 after the scan; any_preset cleared by the next start.
